// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator answering a host start pulse with a 40-bit frame.
// Define DHT11_RESPONDER_CKSUM_ERR_EN to add corrupt_checksum for injecting a bad checksum.
module dht11_responder #(
    parameter int CLK_FREQ_MHZ     = 100,
    parameter int START_LOW_MIN_US = 18000,
    parameter int RESP_GAP_US      = 20,
    parameter int RESP_LOW_US      = 80,
    parameter int RESP_HIGH_US     = 80,
    parameter int BIT_LOW_US       = 50,
    parameter int BIT0_HIGH_US     = 28,
    parameter int BIT1_HIGH_US     = 70,
    parameter int EOT_LOW_US       = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] humidity_int,
    input  logic [7:0] humidity_dec,
    input  logic [7:0] temperature_int,
    input  logic [7:0] temperature_dec,
    inout  wire        dht11_data,
    output logic       busy,
    output logic       frame_done
`ifdef DHT11_RESPONDER_CKSUM_ERR_EN
    ,
    input  logic       corrupt_checksum
`endif
);
    localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

    typedef enum logic [3:0] {
        IDLE, HOST_LOW, WAIT_RELEASE, RESP_GAP, RESP_LOW,
        RESP_HIGH, BIT_LOW, BIT_HIGH, EOT_LOW
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [14:0]   us_q, us_d, dur;
    logic [5:0]    idx_q, idx_d;
    logic [39:0]   frame_q, frame_d;
    logic          sync1_q, sync2_q, line_prev_q;
    logic          frame_done_q, frame_done_d;
    logic          tick, phase_end, fall, latch, corrupt, drive_low;
    logic [7:0]    cksum;

`ifdef DHT11_RESPONDER_CKSUM_ERR_EN
    assign corrupt = corrupt_checksum;
`else
    assign corrupt = 1'b0;
`endif

    assign cksum = (humidity_int + humidity_dec + temperature_int + temperature_dec) ^ {7'd0, corrupt};
    assign tick  = pre_q == PW'(CLK_FREQ_MHZ - 1);
    assign fall  = line_prev_q & ~sync2_q;

    assign dur = (state_q == HOST_LOW)  ? 15'(START_LOW_MIN_US) :
                 (state_q == RESP_GAP)  ? 15'(RESP_GAP_US) :
                 (state_q == RESP_LOW)  ? 15'(RESP_LOW_US) :
                 (state_q == RESP_HIGH) ? 15'(RESP_HIGH_US) :
                 (state_q == BIT_LOW)   ? 15'(BIT_LOW_US) :
                 (state_q == BIT_HIGH)  ? (frame_q[idx_q] ? 15'(BIT1_HIGH_US) : 15'(BIT0_HIGH_US)) :
                 15'(EOT_LOW_US);
    assign phase_end = tick && (us_q == dur - 15'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (fall) state_d = HOST_LOW;
            HOST_LOW:     state_d = sync2_q ? IDLE : (phase_end ? WAIT_RELEASE : HOST_LOW);
            WAIT_RELEASE: if (sync2_q) state_d = RESP_GAP;
            RESP_GAP:     if (phase_end) state_d = RESP_LOW;
            RESP_LOW:     if (phase_end) state_d = RESP_HIGH;
            RESP_HIGH:    if (phase_end) state_d = BIT_LOW;
            BIT_LOW:      if (phase_end) state_d = BIT_HIGH;
            BIT_HIGH:     if (phase_end) state_d = (idx_q == 6'd0) ? EOT_LOW : BIT_LOW;
            EOT_LOW:      if (phase_end) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
        latch        = (state_q == RESP_GAP) && phase_end;
        pre_d        = (state_d != state_q || tick) ? '0 : pre_q + PW'(1);
        us_d         = (state_d != state_q) ? '0 : us_q + {14'd0, tick};
        idx_d        = latch ? 6'd39 : ((state_q == BIT_HIGH && phase_end) ? idx_q - 6'd1 : idx_q);
        frame_d      = latch ? {humidity_int, humidity_dec, temperature_int, temperature_dec, cksum} : frame_q;
        frame_done_d = (state_q == EOT_LOW) && phase_end;
    end

    // Gating with reset releases the bus the moment reset falls, not at the next edge.
    assign drive_low  = reset && (state_q inside {RESP_LOW, BIT_LOW, EOT_LOW});
    assign dht11_data = drive_low ? 1'b0 : 1'bz;
    assign busy       = !(state_q inside {IDLE, HOST_LOW});
    assign frame_done = frame_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pre_q        <= '0;
            us_q         <= '0;
            idx_q        <= '0;
            frame_q      <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            line_prev_q  <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            us_q         <= us_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            sync1_q      <= dht11_data;
            sync2_q      <= sync1_q;
            line_prev_q  <= sync2_q;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: directed host-side bench decoding DHT11 frames from measured pulse widths.
// Runs at 2 clk cycles per us with a 200 us start threshold to keep frames short.
module tb_dht11_responder;
    logic       clk = 1'b0, reset = 1'b0, host_drv = 1'b0;
    logic [7:0] hi, hd, ti, td;
    logic       busy, frame_done;
    wire        dht11_data;
    int         ncmp = 0, nerr = 0, bits_rx = 0;
    int         resp_lo, resp_hi, eot_lo;
    int         bit_lo [40];
    int         bit_hi [40];
    logic [39:0] f;
`ifdef DHT11_RESPONDER_CKSUM_ERR_EN
    logic       corrupt = 1'b0;
`endif

    always #5 clk = ~clk;
    pullup (dht11_data);
    assign dht11_data = host_drv ? 1'b0 : 1'bz;

    dht11_responder #(.CLK_FREQ_MHZ(2), .START_LOW_MIN_US(200)) dut (
        .clk(clk),
        .reset(reset),
        .humidity_int(hi),
        .humidity_dec(hd),
        .temperature_int(ti),
        .temperature_dec(td),
        .dht11_data(dht11_data),
        .busy(busy),
        .frame_done(frame_done)
`ifdef DHT11_RESPONDER_CKSUM_ERR_EN
        ,
        .corrupt_checksum(corrupt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_w(input string tag, input int got, input int us);
        ncmp++;
        assert (got >= us * 2 - 2 && got <= us * 2 + 2) else begin
            nerr++;
            $error("FAIL %s: width %0d cycles expected %0d +/-2", tag, got, us * 2);
        end
    endtask

    task automatic pulse(input logic lvl, output int n);
        int t = 0;
        while (dht11_data !== lvl && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) begin
            ncmp++;
            nerr++;
            $error("FAIL timeout: line never reached %b", lvl);
        end
        n = 0;
        while (dht11_data === lvl && n < 4000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic recv(input int nbits, input bit eot, output logic [39:0] fr);
        fr = '0;
        bits_rx = 0;
        pulse(1'b0, resp_lo);
        pulse(1'b1, resp_hi);
        for (int i = 0; i < nbits; i++) begin
            pulse(1'b0, bit_lo[i]);
            pulse(1'b1, bit_hi[i]);
            fr = {fr[38:0], bit_hi[i] > 98};
            bits_rx = i + 1;
        end
        if (eot) pulse(1'b0, eot_lo);
    endtask

    task automatic host_pulse(input int us, output logic b);
        host_drv = 1'b1;
        repeat (us * 2) @(negedge clk);
        b = busy;
        host_drv = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_in(input logic [31:0] v);
        {hi, hd, ti, td} = v;
    endtask

    initial begin
        logic b;
        int act, bad, t, exp;
        set_in(32'h3C001C00);
        repeat (4) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_line", dht11_data, 1);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        host_pulse(250, b);
        check("a_busy_accept", b, 1);
        recv(40, 1, f);
        check("a_frame", f, 40'h3C001C0058);
        check("a_done", frame_done, 1);
        check("a_busy_end", busy, 0);
        check_w("a_resp_lo", resp_lo, 80);
        check_w("a_resp_hi", resp_hi, 80);
        check_w("a_bit_lo", bit_lo[0], 50);
        check_w("a_bit0_hi", bit_hi[0], 28);
        check_w("a_bit1_hi", bit_hi[2], 70);
        check_w("a_eot_lo", eot_lo, 50);
        @(negedge clk);
        check("a_done_pulse", frame_done, 0);

        set_in(32'hFFFFFF02);
        host_pulse(250, b);
        recv(40, 1, f);
        check("b_frame", f, 40'hFFFFFF02FF);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            exp = f[39 - i] ? 140 : 56;
            if (bit_hi[i] < exp - 2 || bit_hi[i] > exp + 2) bad++;
        end
        check("b_high_widths", bad, 0);

        host_pulse(100, b);
        check("short_busy", b, 0);
        act = 0;
        repeat (1000) begin
            @(negedge clk);
            if (dht11_data === 1'b0 || busy) act++;
        end
        check("short_quiet", act, 0);

        set_in(32'h3C001C00);
        host_pulse(250, b);
        fork
            recv(40, 1, f);
            begin
                wait (bits_rx == 20);
                set_in(32'h00000000);
            end
        join
        check("hold_frame", f, 40'h3C001C0058);

        repeat (10) @(negedge clk);
        host_pulse(250, b);
        repeat (600) @(negedge clk);
        host_pulse(250, b);
        check("ign_busy", b, 1);
        t = 0;
        while (frame_done !== 1'b1 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("ign_done_seen", t < 20000, 1);
        act = 0;
        repeat (1500) begin
            @(negedge clk);
            if (dht11_data === 1'b0 || busy) act++;
        end
        check("ign_no_restart", act, 0);

        set_in(32'h3C001C00);
        host_pulse(250, b);
        recv(29, 0, f);
        check("mid_bit_low", dht11_data, 0);
        reset = 1'b0;
        #1;
        check("rst_mid_line", dht11_data, 1);
        check("rst_mid_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        set_in(32'h12345678);
        host_pulse(250, b);
        recv(40, 1, f);
        check("post_rst_frame", f, 40'h1234567814);

`ifdef DHT11_RESPONDER_CKSUM_ERR_EN
        repeat (10) @(negedge clk);
        corrupt = 1'b1;
        set_in(32'h3C001C00);
        host_pulse(250, b);
        recv(40, 1, f);
        check("cksum_err", f, 40'h3C001C0059);
        corrupt = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
